// File: rtl/oled_spi_write.sv
// Byte-wide SPI mode-0 transmitter (MSB first) for an SSD1306-class OLED panel.
// Optional sticky overrun flag is enabled by defining OLED_SPI_OVERRUN_EN.
module oled_spi_write #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_write,
    input  logic [7:0] data,
    input  logic       oled_dc,
    output logic       write_done,
    output logic       busy,
    output logic       oled_cs,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_dc_pin
`ifdef OLED_SPI_OVERRUN_EN
    ,
    output logic       overrun
`endif
);

    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(7);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_n;
    logic [7:0]       sh;
    logic [7:0]       sh_n;
    logic             dc_q;
    logic             dc_q_n;
    logic             done_n;
    logic             busy_n;
    logic             cs_n;
    logic             sclk_n;
    logic             mosi_n;
    logic             dc_pin_n;
    logic             cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (ena_write) begin
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_last && !oled_sclk && (bit_cnt == '0)) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (cnt_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Next values for outputs and datapath; registered below so pins line up with the state
    always_comb begin
        cnt_n     = '0;
        bit_cnt_n = bit_cnt;
        sh_n      = sh;
        dc_q_n    = dc_q;
        done_n    = 1'b0;
        cs_n      = oled_cs;
        sclk_n    = oled_sclk;
        mosi_n    = oled_mosi;
        dc_pin_n  = oled_dc_pin;
        unique case (state)
            IDLE: begin
                cs_n   = 1'b1;
                sclk_n = 1'b0;
                if (ena_write) begin
                    sh_n      = data;
                    dc_q_n    = oled_dc;
                    dc_pin_n  = oled_dc;
                    mosi_n    = data[7];
                    cs_n      = 1'b0;
                    bit_cnt_n = BIT_FIRST;
                end
            end
            SETUP: begin
                cnt_n    = cnt_last ? '0 : cnt + CNT_W'(1);
                cs_n     = 1'b0;
                dc_pin_n = dc_q;
                mosi_n   = sh[7];
                sclk_n   = cnt_last;
            end
            SHIFT: begin
                cnt_n = cnt_last ? '0 : cnt + CNT_W'(1);
                if (cnt_last) begin
                    if (oled_sclk) begin
                        // Falling edge: present the next bit for the following rising edge
                        sclk_n = 1'b0;
                        if (bit_cnt != '0) begin
                            sh_n   = {sh[6:0], 1'b0};
                            mosi_n = sh[6];
                        end
                    end else if (bit_cnt != '0) begin
                        bit_cnt_n = bit_cnt - BIT_W'(1);
                        sclk_n    = 1'b1;
                    end
                end
            end
            HOLD: begin
                cnt_n  = cnt_last ? '0 : cnt + CNT_W'(1);
                sclk_n = 1'b0;
                if (cnt_last) begin
                    cs_n   = 1'b1;
                    done_n = 1'b1;
                end
            end
            DONE: begin
                cs_n   = 1'b1;
                sclk_n = 1'b0;
            end
            default: begin
                cs_n   = 1'b1;
                sclk_n = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            dc_q        <= 1'b0;
            write_done  <= 1'b0;
            busy        <= 1'b0;
            oled_cs     <= 1'b1;
            oled_sclk   <= 1'b0;
            oled_mosi   <= 1'b0;
            oled_dc_pin <= 1'b1;
        end else begin
            cnt         <= cnt_n;
            bit_cnt     <= bit_cnt_n;
            sh          <= sh_n;
            dc_q        <= dc_q_n;
            write_done  <= done_n;
            busy        <= busy_n;
            oled_cs     <= cs_n;
            oled_sclk   <= sclk_n;
            oled_mosi   <= mosi_n;
            oled_dc_pin <= dc_pin_n;
        end
    end

`ifdef OLED_SPI_OVERRUN_EN
    // Sticky: any request arriving outside IDLE, including the DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ena_write && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_oled_spi_write.sv
// Randomized self-checking bench for oled_spi_write: one instance at CLK_DIV=4, one at CLK_DIV=1.
`timescale 1ns/1ps
module tb_oled_spi_write;

    logic       clk;
    logic       rst_w   [2];
    logic       ena_w   [2];
    logic [7:0] data_w  [2];
    logic       dc_w    [2];
    logic       done_o  [2];
    logic       busy_o  [2];
    logic       cs_o    [2];
    logic       sclk_o  [2];
    logic       mosi_o  [2];
    logic       dcp_o   [2];
`ifdef OLED_SPI_OVERRUN_EN
    logic       ovr_o   [2];
`endif

    int passed = 0;
    int total  = 0;

    oled_spi_write #(.CLK_DIV(4), .CNT_W(8)) u_div4 (
        .clk(clk), .rst(rst_w[0]), .ena_write(ena_w[0]), .data(data_w[0]), .oled_dc(dc_w[0]),
        .write_done(done_o[0]), .busy(busy_o[0]), .oled_cs(cs_o[0]), .oled_sclk(sclk_o[0]),
        .oled_mosi(mosi_o[0]), .oled_dc_pin(dcp_o[0])
`ifdef OLED_SPI_OVERRUN_EN
        , .overrun(ovr_o[0])
`endif
    );

    oled_spi_write #(.CLK_DIV(1), .CNT_W(8)) u_div1 (
        .clk(clk), .rst(rst_w[1]), .ena_write(ena_w[1]), .data(data_w[1]), .oled_dc(dc_w[1]),
        .write_done(done_o[1]), .busy(busy_o[1]), .oled_cs(cs_o[1]), .oled_sclk(sclk_o[1]),
        .oled_mosi(mosi_o[1]), .oled_dc_pin(dcp_o[1])
`ifdef OLED_SPI_OVERRUN_EN
        , .overrun(ovr_o[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {done,busy,cs,sclk,mosi,dc_pin} k cycles after the request cycle
    function automatic logic [5:0] exp_vec(input int k, input int kd, input logic [7:0] b, input logic dc);
        int j, bt;
        logic hi, m;
        if (k <= kd) return {1'b0, 1'b1, 1'b0, 1'b0, b[7], dc};
        if (k <= 17 * kd) begin
            j  = k - kd - 1;
            bt = j / (2 * kd);
            hi = ((j / kd) % 2) == 0;
            if (hi)          m = b[7 - bt];
            else if (bt < 7) m = b[6 - bt];
            else             m = b[0];
            return {1'b0, 1'b1, 1'b0, hi, m, dc};
        end
        if (k <= 18 * kd)     return {1'b0, 1'b1, 1'b0, 1'b0, b[0], dc};
        if (k == 18 * kd + 1) return {1'b1, 1'b1, 1'b1, 1'b0, b[0], dc};
        return {1'b0, 1'b0, 1'b1, 1'b0, b[0], dc};
    endfunction

    function automatic logic [5:0] obs_vec(input int u);
        return {done_o[u], busy_o[u], cs_o[u], sclk_o[u], mosi_o[u], dcp_o[u]};
    endfunction

    // Drive one request and watch the frame up to two cycles past write_done
    task automatic run_frame(input int u, input logic [7:0] b, input logic dc, input bit poke,
                             output int errs, output logic [7:0] got, output int ndone, output int lat);
        int kd, n;
        logic prev;
        kd = (u == 0) ? 4 : 1;
        n  = 18 * kd + 2;
        @(negedge clk);
        ena_w[u] = 1'b1; data_w[u] = b; dc_w[u] = dc;
        errs = 0; got = '0; ndone = 0; lat = -1; prev = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ena_w[u]  = poke && (k == 10 || k == 18 * kd + 1);
            data_w[u] = 8'($urandom);
            dc_w[u]   = 1'($urandom);
            if (obs_vec(u) !== exp_vec(k, kd, b, dc)) begin
                if (errs == 0)
                    $display("  first wave diff u=%0d k=%0d got=%b want=%b", u, k, obs_vec(u), exp_vec(k, kd, b, dc));
                errs++;
            end
            if (sclk_o[u] && !prev) got = {got[6:0], mosi_o[u]};
            prev = sclk_o[u];
            if (done_o[u]) begin
                ndone++;
                lat = k;
            end
`ifdef OLED_SPI_OVERRUN_EN
            if (poke && k >= 11 && ovr_o[u] !== 1'b1) errs++;
`endif
        end
        ena_w[u] = 1'b0;
    endtask

    task automatic check_frame(input string name, input int u, input logic [7:0] b, input logic dc, input bit poke);
        int errs, ndone, lat, kd;
        logic [7:0] got;
        kd = (u == 0) ? 4 : 1;
        run_frame(u, b, dc, poke, errs, got, ndone, lat);
        total++;
        if (errs !== 0) $display("FAIL %s_wave: %0d cycle mismatches, required 0", name, errs);
        else passed++;
        total++;
        if (got !== b) $display("FAIL %s_byte: sampled %h, required %h", name, got, b);
        else passed++;
        total++;
        if (ndone !== 1) $display("FAIL %s_done_count: %0d pulses, required 1", name, ndone);
        else passed++;
        total++;
        if (lat !== 18 * kd + 1) $display("FAIL %s_latency: %0d cycles, required %0d", name, lat, 18 * kd + 1);
        else passed++;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            rst_w[u] = 1'b1; ena_w[u] = 1'b0; data_w[u] = '0; dc_w[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (obs_vec(u) !== 6'b001001) $display("FAIL reset_u%0d: got %b, required 001001", u, obs_vec(u));
            else passed++;
`ifdef OLED_SPI_OVERRUN_EN
            total++;
            if (ovr_o[u] !== 1'b0) $display("FAIL reset_overrun_u%0d: got %b, required 0", u, ovr_o[u]);
            else passed++;
`endif
        end
        rst_w[0] = 1'b0; rst_w[1] = 1'b0;
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cs_o[0] !== 1'b1 || sclk_o[0] !== 1'b0 || done_o[0] !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL idle_hold: %0d bad cycles, required 0", bad);
        else passed++;
    endtask

    task automatic test_basic();
        check_frame("basic_a5", 0, 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            check_frame("random", 0, 8'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        check_frame("b2b_cmd", 0, 8'hB7, 1'b0, 1'b0);
        check_frame("b2b_data", 0, 8'h3C, 1'b1, 1'b0);
    endtask

    task automatic test_ignore();
        check_frame("ignore_ff", 0, 8'hFF, 1'b1, 1'b1);
    endtask

    task automatic test_mid_reset();
        int ndone = 0;
        @(negedge clk);
        ena_w[0] = 1'b1; data_w[0] = 8'h5A; dc_w[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            ena_w[0] = 1'b0;
            if (k == 30) rst_w[0] = 1'b1;
        end
        @(negedge clk);
        total++;
        if (obs_vec(0) !== 6'b001001) $display("FAIL mid_reset_outputs: got %b, required 001001", obs_vec(0));
        else passed++;
        rst_w[0] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done_o[0]) ndone++;
        end
        total++;
        if (ndone !== 0) $display("FAIL mid_reset_no_done: %0d pulses, required 0", ndone);
        else passed++;
        check_frame("after_reset_00", 0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_div1();
        check_frame("div1_81", 1, 8'h81, 1'b1, 1'b0);
        check_frame("div1_rand", 1, 8'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_random();
        test_back_to_back();
        test_ignore();
        test_mid_reset();
        test_div1();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
